// File: rtl/lsu_misalign_seq.sv
// Memory-stage sequencer: aligned accesses pass straight through, misaligned LH/LHU/LW/SH/SW are split
// into byte accesses with the pipeline stalled. Build macro LSU_MISALIGN_TRAP_EN replaces splitting with a trap pulse.
module lsu_misalign_seq #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_func3,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ld_data,
    output logic              stall,
    output logic              misalign_trap
);
    logic w_qual;
    logic w_listed;
    logic w_misalign;

    // Request decode: qualification, legal encodings and misalignment
    always_comb begin
        w_qual = req_valid & (is_load ^ is_store);
        if (is_load) begin
            w_listed = (func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111);
        end else begin
            w_listed = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
        end
        case (func3[1:0])
            2'b01:   w_misalign = w_qual & w_listed & addr[0];
            2'b10:   w_misalign = w_qual & w_listed & (addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Pass-through with a one-cycle trap instead of splitting
    always_comb begin
        mem_addr      = addr;
        mem_wdata     = wdata;
        mem_func3     = func3;
        mem_rd_en     = 1'b0;
        mem_wr_en     = 1'b0;
        ld_data       = 32'd0;
        stall         = 1'b0;
        misalign_trap = 1'b0;
        if (!rst_n) begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = 32'd0;
            mem_func3 = 3'd0;
        end else if (w_misalign) begin
            misalign_trap = 1'b1;
        end else if (w_qual) begin
            mem_rd_en = is_load;
            mem_wr_en = is_store;
            ld_data   = is_load ? mem_rdata : 32'd0;
        end else begin
            misalign_trap = 1'b0;
        end
    end
`else
    typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;

    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SB  = 3'b000;

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nx;
    logic [23:0]       r_buf;
    logic [23:0]       w_buf_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_func3;
    logic              r_load;
    logic              w_latch;

    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        case (sz)
            2'b01:   last_idx = 2'd1;
            2'b10:   last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    // The top byte comes straight from memory in the final cycle, earlier bytes from the buffer
    function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [23:0] lo, input logic [7:0] hi);
        case (f3)
            3'b001:  ld_extend = {{16{hi[7]}}, hi, lo[7:0]};
            3'b101:  ld_extend = {16'd0, hi, lo[7:0]};
            3'b010:  ld_extend = {hi, lo};
            default: ld_extend = 32'd0;
        endcase
    endfunction

    // State, byte index, load buffer and latched request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_buf   <= 24'd0;
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= 32'd0;
            r_func3 <= 3'd0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_buf   <= w_buf_nx;
            if (w_latch) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_func3 <= func3;
                r_load  <= is_load;
            end else begin
                r_load  <= r_load;
            end
        end
    end

    // Next state and memory-port drive
    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_buf_nx      = r_buf;
        w_latch       = 1'b0;
        mem_addr      = addr;
        mem_wdata     = wdata;
        mem_func3     = func3;
        mem_rd_en     = 1'b0;
        mem_wr_en     = 1'b0;
        ld_data       = 32'd0;
        stall         = 1'b0;
        misalign_trap = 1'b0;
        if (!rst_n) begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = 32'd0;
            mem_func3 = 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_misalign) begin
                        mem_wdata  = {24'd0, wdata[7:0]};
                        mem_func3  = is_load ? F3_LBU : F3_SB;
                        mem_rd_en  = is_load;
                        mem_wr_en  = is_store;
                        stall      = 1'b1;
                        w_latch    = 1'b1;
                        w_idx_nx   = 2'd1;
                        w_state_nx = S_SPLIT;
                        w_buf_nx   = is_load ? {16'd0, mem_rdata[7:0]} : r_buf;
                    end else if (w_qual) begin
                        mem_rd_en = is_load;
                        mem_wr_en = is_store;
                        ld_data   = is_load ? mem_rdata : 32'd0;
                    end else begin
                        stall = 1'b0;
                    end
                end
                S_SPLIT: begin
                    mem_addr  = r_addr + {{(ADDR_W-2){1'b0}}, r_idx};
                    mem_func3 = r_load ? F3_LBU : F3_SB;
                    mem_wdata = {24'd0, byte_sel(r_wdata, r_idx)};
                    mem_rd_en = r_load;
                    mem_wr_en = ~r_load;
                    if (r_idx < last_idx(r_func3[1:0])) begin
                        stall    = 1'b1;
                        w_idx_nx = r_idx + 2'd1;
                        if (r_load) begin
                            case (r_idx)
                                2'd1:    w_buf_nx[15:8]  = mem_rdata[7:0];
                                2'd2:    w_buf_nx[23:16] = mem_rdata[7:0];
                                default: w_buf_nx        = r_buf;
                            endcase
                        end else begin
                            w_buf_nx = r_buf;
                        end
                    end else begin
                        w_state_nx = S_IDLE;
                        w_idx_nx   = 2'd0;
                        ld_data    = r_load ? ld_extend(r_func3, r_buf, mem_rdata[7:0]) : 32'd0;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Self-checking bench for lsu_misalign_seq: byte-array data memory, transaction-level expected-cycle model.
module tb_lsu_misalign_seq;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, is_load, is_store;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    func3;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_func3;
    logic          mem_rd_en, mem_wr_en;
    logic [31:0]   mem_rdata;
    logic [31:0]   ld_data;
    logic          stall, misalign_trap;

    lsu_misalign_seq #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
        .addr(addr), .wdata(wdata), .func3(func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
        .ld_data(ld_data), .stall(stall), .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk_mem;
        logic [10:0] a;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] wm;
        logic        rd;
        logic        wr;
        logic        stl;
        logic        trp;
        logic [31:0] ld;
        logic        fin;
    } exp_t;

    exp_t        expq[$];
    logic [10:0] addr_log[$];
    logic [7:0]  mem[0:2047];
    logic [7:0]  ref_mem[0:2047];
    logic [31:0] last_ld;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        pl_all, pl_en;
    logic [10:0] pl_addr;
    logic [7:0]  pl_data;

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  ext = {{24{w[7]}}, w[7:0]};
            3'b100:  ext = {24'd0, w[7:0]};
            3'b001:  ext = {{16{w[15]}}, w[15:0]};
            3'b101:  ext = {16'd0, w[15:0]};
            default: ext = w;
        endcase
    endfunction

    // data memory: combinational read, negedge write
    always_comb mem_rdata = ext(mem_func3, {mem[mem_addr + 11'd3], mem[mem_addr + 11'd2],
                                            mem[mem_addr + 11'd1], mem[mem_addr]});

    always @(negedge clk) begin
        if (pl_all) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) mem[mem_addr + 11'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                mem[mem_addr + 11'd2] <= mem_wdata[23:16];
                mem[mem_addr + 11'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // compare process: one expected record per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #3;
            if (mem_rd_en === 1'b1 || mem_wr_en === 1'b1) addr_log.push_back(mem_addr);
            if (expq.size() > 0) begin
                e  = expq.pop_front();
                ok = (mem_rd_en === e.rd) && (mem_wr_en === e.wr) && (stall === e.stl) &&
                     (misalign_trap === e.trp) && (ld_data === e.ld);
                if (e.chk_mem)
                    ok = ok && (mem_addr === e.a) && (mem_func3 === e.f3) &&
                         ((mem_wdata & e.wm) === (e.wd & e.wm));
                if (e.fin) last_ld = ld_data;
                n_vec++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t: rd/wr/stall/trap got %b%b%b%b exp %b%b%b%b addr got %h exp %h f3 got %h exp %h wdata got %h exp %h/%h ld got %h exp %h",
                             $time, mem_rd_en, mem_wr_en, stall, misalign_trap, e.rd, e.wr, e.stl, e.trp,
                             mem_addr, e.a, mem_func3, e.f3, mem_wdata, e.wd, e.wm, ld_data, e.ld);
                end
            end
        end
    end

    // Apply one request (entered at posedge+1) and queue the cycles it must produce.
    task automatic req(input logic v, input logic ldf, input logic stf, input logic [10:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
        exp_t        e;
        logic        qual, listed, mis;
        int          n, cyc;
        logic [31:0] val;
        logic [10:0] ak;
        req_valid = v; is_load = ldf; is_store = stf; addr = a; wdata = wd; func3 = f3;
        qual   = v && (ldf != stf);
        n      = (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 1;
        listed = ldf ? !(f3 inside {3'b011, 3'b110, 3'b111}) : (f3 inside {3'b000, 3'b001, 3'b010});
        mis    = qual && listed && ((int'(a) % n) != 0);
        e = '{chk_mem: 1'b0, a: a, f3: f3, wd: wd, wm: 32'hFFFFFFFF, rd: 1'b0, wr: 1'b0,
              stl: 1'b0, trp: 1'b0, ld: 32'd0, fin: 1'b0};
        cyc = 1;
        val = 32'd0;
        for (int k = 0; k < 4; k++) val[8*k +: 8] = ref_mem[a + 11'(k)];
        if (!qual) begin
            expq.push_back(e);
        end else if (!mis) begin
            e.chk_mem = 1'b1; e.rd = ldf; e.wr = stf; e.fin = ldf;
            e.ld = ldf ? ext(f3, val) : 32'd0;
            expq.push_back(e);
            if (stf) for (int k = 0; k < n; k++) ref_mem[a + 11'(k)] = wd[8*k +: 8];
        end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            e.trp = 1'b1;
            expq.push_back(e);
`else
            if (n == 2) val = (f3 == 3'b001) ? {{16{val[15]}}, val[15:0]} : {16'd0, val[15:0]};
            cyc = n;
            for (int k = 0; k < n; k++) begin
                ak = a + 11'(k);
                e = '{chk_mem: 1'b1, a: ak, f3: (ldf ? 3'b100 : 3'b000), wd: {24'd0, wd[8*k +: 8]},
                      wm: 32'h000000FF, rd: ldf, wr: stf, stl: (k < n - 1), trp: 1'b0,
                      ld: ((k == n - 1) && ldf) ? val : 32'd0, fin: (k == n - 1) && ldf};
                expq.push_back(e);
                if (stf) ref_mem[ak] = wd[8*k +: 8];
            end
`endif
        end
        for (int k = 1; k < cyc; k++) begin
            @(posedge clk);
            #1;
            addr = ~a; wdata = ~wd; func3 = 3'b000;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
        addr = 11'h123; wdata = 32'hDEADBEEF; func3 = 3'b010;
        pl_all = 1'b0; pl_en = 1'b0; pl_addr = 11'd0; pl_data = 8'd0; last_ld = 32'd0;
        #3;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("reset wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("reset mem_addr", {21'd0, mem_addr}, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset mem_func3", {29'd0, mem_func3}, 32'd0);
        chk("reset ld_data", ld_data, 32'd0);
        chk("reset trap", {31'd0, misalign_trap}, 32'd0);

        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i * 7 + 3);
        pl_all = 1'b1;
        @(negedge clk);
        #1;
        pl_all = 1'b0;
        preload(11'h010, 8'h44); preload(11'h011, 8'h33); preload(11'h012, 8'h22); preload(11'h013, 8'h11);
        preload(11'h101, 8'h80); preload(11'h102, 8'hFF);
        preload(11'h7FE, 8'h01); preload(11'h7FF, 8'h02); preload(11'h000, 8'h03); preload(11'h001, 8'h04);
        preload(11'h004, 8'h5A);
        req_valid = 1'b0; is_load = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        req(1'b0, 1'b0, 1'b0, 11'h0, 32'd0, 3'b000);
        req(1'b1, 1'b1, 1'b0, 11'h010, 32'd0, 3'b010);
        chk("aligned LW", last_ld, 32'h11223344);

        addr_log.delete();
        req(1'b1, 1'b0, 1'b1, 11'h005, 32'hA1B2C3D4, 3'b010);
        req(1'b1, 1'b1, 1'b0, 11'h004, 32'd0, 3'b010);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("SW split addr count", addr_log.size(), 32'd5);
        chk("SW split addr0", {21'd0, addr_log[0]}, 32'h005);
        chk("SW split addr3", {21'd0, addr_log[3]}, 32'h008);
        chk("SW byte 0x005", {24'd0, mem[5]}, 32'hD4);
        chk("SW byte 0x008", {24'd0, mem[8]}, 32'hA1);
        chk("LW after split SW", last_ld, 32'hB2C3D45A);
`endif

        req(1'b1, 1'b1, 1'b0, 11'h101, 32'd0, 3'b001);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("split LH", last_ld, 32'hFFFFFF80);
`endif
        req(1'b1, 1'b1, 1'b0, 11'h101, 32'd0, 3'b101);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("split LHU", last_ld, 32'h0000FF80);
`endif

        addr_log.delete();
        req(1'b1, 1'b1, 1'b0, 11'h7FE, 32'd0, 3'b010);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("wrap LW", last_ld, 32'h04030201);
        chk("wrap addr1", {21'd0, addr_log[1]}, 32'h7FF);
        chk("wrap addr2", {21'd0, addr_log[2]}, 32'h000);
        chk("wrap addr3", {21'd0, addr_log[3]}, 32'h001);
`endif

        req(1'b1, 1'b0, 1'b1, 11'h021, 32'h00001234, 3'b001);
        req(1'b1, 1'b1, 1'b0, 11'h021, 32'd0, 3'b001);
        req(1'b1, 1'b0, 1'b1, 11'h023, 32'h0000BEEF, 3'b001);
        req(1'b1, 1'b1, 1'b0, 11'h022, 32'd0, 3'b010);
        req(1'b1, 1'b1, 1'b0, 11'h023, 32'd0, 3'b101);
        req(1'b1, 1'b0, 1'b1, 11'h030, 32'hCAFE0077, 3'b000);
        req(1'b1, 1'b1, 1'b0, 11'h030, 32'd0, 3'b000);
        req(1'b1, 1'b1, 1'b0, 11'h7FF, 32'd0, 3'b100);
        req(1'b1, 1'b1, 1'b0, 11'h003, 32'd0, 3'b011);
        req(1'b1, 1'b1, 1'b1, 11'h041, 32'h11111111, 3'b010);
        req(1'b1, 1'b0, 1'b0, 11'h041, 32'h11111111, 3'b010);
        req(1'b1, 1'b0, 1'b1, 11'h040, 32'h89ABCDEF, 3'b010);
        req(1'b1, 1'b1, 1'b0, 11'h041, 32'd0, 3'b010);
        req(1'b1, 1'b1, 1'b0, 11'h043, 32'd0, 3'b001);
        req(1'b1, 1'b1, 1'b0, 11'h042, 32'd0, 3'b001);
        req(1'b1, 1'b0, 1'b1, 11'h7FF, 32'h00005566, 3'b001);
        req(1'b1, 1'b1, 1'b0, 11'h7FF, 32'd0, 3'b001);
        req(1'b1, 1'b1, 1'b0, 11'h002, 32'd0, 3'b010);

`ifndef LSU_MISALIGN_TRAP_EN
        req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; addr = 11'h003; wdata = 32'h9ABCDEE4; func3 = 3'b010;
        expq.push_back('{chk_mem: 1'b1, a: 11'h003, f3: 3'b000, wd: 32'h000000E4, wm: 32'h000000FF,
                         rd: 1'b0, wr: 1'b1, stl: 1'b1, trp: 1'b0, ld: 32'd0, fin: 1'b0});
        ref_mem[3] = 8'hE4;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-split reset stall", {31'd0, stall}, 32'd0);
        chk("mid-split reset wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("mid-split reset rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("mid-split reset mem_addr", {21'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; is_store = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mid-split byte 0x003", {24'd0, mem[3]}, 32'hE4);
        chk("mid-split byte 0x004", {24'd0, mem[4]}, 32'h5A);
        req(1'b1, 1'b1, 1'b0, 11'h004, 32'd0, 3'b010);
        chk("LW after reset", last_ld, {mem[7], mem[6], mem[5], 8'h5A});
`endif

        req(1'b0, 1'b0, 1'b0, 11'h0, 32'd0, 3'b000);
        req(1'b0, 1'b0, 1'b0, 11'h0, 32'd0, 3'b000);
        chk("expected queue drained", expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
